// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 64-bit doubleword-indexed data memory.
// Checks alignment/range, performs read-modify-write for sub-doubleword stores.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        fault_q;
  logic [63:0] maddr_q;
  logic [63:0] mwdata_q;

  logic        fault_d;
  logic [63:0] load_d;
  logic [63:0] merged_d;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic check_fault(input logic [1:0] size, input logic [63:0] addr);
    logic misaligned;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
    return misaligned || (addr[63:3] >= 61'(MEM_WORDS));
  endfunction

  // Lane is selected little-endian by byte offset; doubleword ignores unsigned.
  function automatic logic [63:0] extend_load(input logic [63:0] word, input logic [2:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    return uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    return uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [63:0] merge_store(input logic [63:0] old, input logic [63:0] wdata,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] m;
    m = size_mask(size) << {off, 3'b000};
    return (old & ~m) | ((wdata << {off, 3'b000}) & m);
  endfunction

  always_comb begin
    fault_d  = check_fault(req_size, req_addr);
    load_d   = extend_load(mem_rdata, off_q, size_q, uns_q);
    merged_d = merge_store(mem_rdata, wdata_q, off_q, size_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      off_q    <= 3'd0;
      wdata_q  <= 64'd0;
      rdata_q  <= 64'd0;
      fault_q  <= 1'b0;
      maddr_q  <= 64'd0;
      mwdata_q <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[2:0];
            wdata_q <= req_wdata;
            maddr_q <= {3'b000, req_addr[63:3]};
            fault_q <= fault_d;
            if (fault_d || req_write) rdata_q <= 64'd0;
            if (req_write && req_size == 2'd3) mwdata_q <= req_wdata;
            if (fault_d)                                 state_q <= RESP;
            else if (req_write && req_size == 2'd3)      state_q <= WRITE;
            else                                         state_q <= READ;
          end
        end
        READ: begin
          if (wr_q) begin
            mwdata_q <= merged_d;
            state_q  <= WRITE;
          end else begin
            rdata_q <= load_d;
            state_q <= RESP;
          end
        end
        WRITE:   state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_read   = (state_q == READ);
  assign mem_write  = (state_q == WRITE);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [63:0] pl_data = 64'd0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  // The memory shares the system reset, so a write strobe coinciding with reset is dropped.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write && rst_n) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic preload(input logic [7:0] idx, input logic [63:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request and observes it until resp_valid (lat = -1 on timeout).
  task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output int lat, output int nrd, output int nwr,
                        output logic [63:0] rdata, output logic fault,
                        output logic [63:0] waddr, output logic [63:0] wword);
    lat = -1; nrd = 0; nwr = 0; rdata = 'x; fault = 1'bx; waddr = 'x; wword = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; waddr = mem_addr; wword = mem_wdata; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; fault = resp_fault; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {mem_read, mem_write}); end
    n_cmp++; if (resp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    n_cmp++; if (mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_cmp++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", resp_fault); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte_loads;
    int lat, nrd, nwr; logic [63:0] rd, wa, ww; logic f;
    preload(8'd2, 64'h8877665544332211);
    do_req(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (rd !== 64'hFFFFFFFFFFFFFF88) begin n_fail++; $display("FAIL lb_signed_data got %h want ffffffffffffff88", rd); end
    n_cmp++; if (f !== 1'b0) begin n_fail++; $display("FAIL lb_signed_fault got %b want 0", f); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lb_signed_latency got %0d want 2", lat); end
    n_cmp++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL lb_signed_access got rd=%0d wr=%0d want 1/0", nrd, nwr); end
    do_req(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (rd !== 64'h0000000000000088) begin n_fail++; $display("FAIL lbu_data got %h want 88", rd); end
    do_req(1'b0, 2'd1, 1'b0, 64'h12, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (rd !== 64'h0000000000004433) begin n_fail++; $display("FAIL lh_data got %h want 4433", rd); end
    do_req(1'b0, 2'd3, 1'b1, 64'h10, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (rd !== 64'h8877665544332211) begin n_fail++; $display("FAIL ld_unsigned_data got %h want 8877665544332211", rd); end
    // Response data persists after the response until the next load completes.
    @(negedge clk);
    n_cmp++; if (resp_rdata !== 64'h8877665544332211) begin n_fail++; $display("FAIL rdata_hold got %h want 8877665544332211", resp_rdata); end
  endtask

  task automatic test_half_rmw;
    int lat, nrd, nwr; logic [63:0] rd, wa, ww; logic f;
    preload(8'd3, 64'hFFFFFFFFFFFFFFFF);
    do_req(1'b1, 2'd1, 1'b0, 64'h1A, 64'h1234, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (nrd !== 1 || nwr !== 1) begin n_fail++; $display("FAIL sh_access got rd=%0d wr=%0d want 1/1", nrd, nwr); end
    n_cmp++; if (wa !== 64'd3) begin n_fail++; $display("FAIL sh_waddr got %h want 3", wa); end
    n_cmp++; if (ww !== 64'hFFFFFFFF1234FFFF) begin n_fail++; $display("FAIL sh_wdata got %h want ffffffff1234ffff", ww); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 64'd0 || f !== 1'b0) begin n_fail++; $display("FAIL sh_resp got %h/%b want 0/0", rd, f); end
    n_cmp++; if (mem[3] !== 64'hFFFFFFFF1234FFFF) begin n_fail++; $display("FAIL sh_mem got %h want ffffffff1234ffff", mem[3]); end
  endtask

  task automatic test_dword_store_load;
    int lat, nrd, nwr; logic [63:0] rd, wa, ww; logic f;
    do_req(1'b1, 2'd3, 1'b0, 64'h40, 64'hDEADBEEFCAFEF00D, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (nrd !== 0 || nwr !== 1) begin n_fail++; $display("FAIL sd_access got rd=%0d wr=%0d want 0/1", nrd, nwr); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sd_latency got %0d want 2", lat); end
    n_cmp++; if (wa !== 64'd8 || ww !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL sd_bus got %h/%h want 8/deadbeefcafef00d", wa, ww); end
    do_req(1'b0, 2'd2, 1'b0, 64'h44, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (rd !== 64'hFFFFFFFFDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h want ffffffffdeadbeef", rd); end
    do_req(1'b0, 2'd2, 1'b1, 64'h40, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (rd !== 64'h00000000CAFEF00D) begin n_fail++; $display("FAIL lwu_data got %h want cafef00d", rd); end
  endtask

  task automatic test_faults;
    int lat, nrd, nwr; logic [63:0] rd, wa, ww; logic f;
    do_req(1'b0, 2'd2, 1'b0, 64'h42, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (f !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0 || rd !== 64'd0)
      begin n_fail++; $display("FAIL fault_lw_misaligned got f=%b lat=%0d rd=%0d wr=%0d data=%h want 1/1/0/0/0", f, lat, nrd, nwr, rd); end
    do_req(1'b1, 2'd3, 1'b0, 64'h801, 64'h55, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (f !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0)
      begin n_fail++; $display("FAIL fault_sd_misaligned got f=%b lat=%0d rd=%0d wr=%0d want 1/1/0/0", f, lat, nrd, nwr); end
    do_req(1'b0, 2'd3, 1'b0, 64'h800, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (f !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0)
      begin n_fail++; $display("FAIL fault_ld_range got f=%b lat=%0d rd=%0d wr=%0d want 1/1/0/0", f, lat, nrd, nwr); end
    do_req(1'b0, 2'd3, 1'b0, 64'h7F8, 64'd0, lat, nrd, nwr, rd, f, wa, ww);
    n_cmp++; if (f !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL last_word_ok got f=%b lat=%0d want 0/2", f, lat); end
  endtask

  task automatic test_back_to_back;
    preload(8'd6, 64'h00000000000080F1);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h10; req_wdata = 64'd0;
    @(posedge clk); @(negedge clk);
    // READ of the first load; present the second request, which must not disturb it.
    n_cmp++; if (req_ready !== 1'b0 || mem_read !== 1'b1) begin n_fail++; $display("FAIL b2b_read got ready=%b rd=%b want 0/1", req_ready, mem_read); end
    req_size = 2'd1; req_addr = 64'h30;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 64'h11)
      begin n_fail++; $display("FAIL b2b_first got v=%b ready=%b data=%h want 1/0/11", resp_valid, req_ready, resp_rdata); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got ready=%b v=%b want 1/0", req_ready, resp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 64'd6) begin n_fail++; $display("FAIL b2b_second_read got rd=%b addr=%h want 1/6", mem_read, mem_addr); end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFFFFFFFFFF80F1)
      begin n_fail++; $display("FAIL b2b_second got v=%b data=%h want 1/ffffffffffff80f1", resp_valid, resp_rdata); end
  endtask

  task automatic test_reset_mid_rmw;
    bit seen = 1'b0;
    preload(8'd5, 64'h1111111111111111);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 64'h28; req_wdata = 64'hAA;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_in_write got %b want 1", mem_write); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_strobes got %b%b want 00", mem_read, mem_write); end
    if (resp_valid) seen = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_no_resp got %b want 0", seen); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_ready got %b want 1", req_ready); end
    n_cmp++; if (mem[5] !== 64'h1111111111111111) begin n_fail++; $display("FAIL rst_rmw_mem got %h want 1111111111111111", mem[5]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    test_reset();
    test_byte_loads();
    test_half_rmw();
    test_dword_store_load();
    test_faults();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the 64-bit doubleword-indexed Data_Memory.
- Accepts one load/store request at a time and checks alignment and range.
- Drives Data_Memory's MemRead/MemWrite/address/write_data. Data_Memory has no byte enables, so sub-doubleword stores are done as read-modify-write.
- Returns sign- or zero-extended load data and a fault flag to the writeback path.

Parameters:
- MEM_WORDS, 256: number of 64-bit words in the attached memory; a doubleword index >= MEM_WORDS is a fault.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word, 3 doubleword
- req_unsigned  input  1  zero-extend load (ignored for doubleword and stores)
- req_addr  input  64  byte address
- req_wdata  input  64  store data, low-order bytes used
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  64  extended load data
- resp_fault  output  1  misaligned or out-of-range; qualified by resp_valid
- mem_read  output  1  to Data_Memory MemRead
- mem_write  output  1  to Data_Memory MemWrite
- mem_addr  output  64  doubleword index, {3'b0, addr[63:3]}
- mem_wdata  output  64  full merged doubleword
- mem_rdata  input  64  Data_Memory read_data, combinational in same cycle as mem_read

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - resp_valid, resp_fault, mem_read, mem_write become 0.
  - resp_rdata, mem_addr, mem_wdata and the latched request become 0.
  - A reset during READ or WRITE aborts the operation. Strobes drop after the reset edge, and no resp_valid is produced for the aborted request.
- FSM states: IDLE, READ, WRITE, RESP. mem_read and mem_write are decoded from the state register only, never from req_* inputs.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch write/size/unsigned/addr/wdata.
  - Fault check:
    - half with addr[0]!=0 → fault
    - word with addr[1:0]!=0 → fault
    - dword with addr[2:0]!=0 → fault
    - addr[63:3] >= MEM_WORDS → fault
  - Next state:
    - fault → RESP with fault=1, no memory access
    - load → READ
    - dword store → WRITE
    - byte/half/word store → READ (RMW)
- READ:
  - mem_read=1 and mem_addr=index for one cycle.
  - mem_rdata is captured at the end of the cycle.
  - Load: extract the lane at byte offset addr[2:0] (little-endian), sign- or zero-extend per req_unsigned, store into resp_rdata, then go to RESP.
  - Store: merge the low size bytes of wdata into the captured word at the same lane, place the result on mem_wdata, then go to WRITE.
- WRITE: mem_write=1 for exactly one cycle with stable mem_addr/mem_wdata, then go to RESP.
- RESP:
  - resp_valid=1 for one cycle, then IDLE.
  - Responses have no backpressure.
  - resp_rdata is 0 for stores and faults; otherwise it holds its value until the next load completes.
- Latency, counted as cycles from the acceptance edge to the cycle resp_valid is high:
  - fault: 1
  - load: 2
  - dword store: 2
  - sub-dword store: 3
- Throughput: the next request can be accepted in the cycle after RESP. req_valid is ignored outside IDLE.
- req_unsigned=1 with size 3 behaves exactly as signed.

Test Plan:
- Reset mid-RMW: issue a byte store, assert rst_n=0 during its WRITE state → mem_write=0 in the next cycle, no resp_valid, req_ready=1 after rst_n returns to 1, target word unchanged.
- Signed and unsigned byte loads: mem[2]=64'h8877665544332211, load byte at addr 0x17 → resp_rdata=64'hFFFFFFFFFFFFFF88, fault=0, latency 2. Same load with req_unsigned=1 → 64'h0000000000000088.
- Half RMW store: mem[3]=64'hFFFFFFFFFFFFFFFF, store half req_wdata=64'h1234 at addr 0x1A → exactly one mem_read, then one mem_write with mem_addr=3 and mem_wdata=64'hFFFFFFFF1234FFFF, resp_valid 3 cycles after acceptance.
- Dword store then load: store 64'hDEADBEEFCAFEF00D to addr 0x40 → no mem_read. A following word load at 0x44 returns 64'hFFFFFFFFDEADBEEF.
- Faults, each giving resp_valid with resp_fault=1 after 1 cycle and no mem_read/mem_write:
  - word load at 0x42
  - dword store at 0x801 (misaligned, MEM_WORDS=256)
  - dword load at 0x800 (out of range)
- Back-to-back: hold req_valid high for two loads → req_ready=0 during READ/RESP, second request accepted in the cycle after the first resp_valid, both results correct.
